// File: rtl/adder_buf_pkg.sv
// Shared types and default sizing for the adder result buffer.
// The FSM encoding is private to this block; widths default to an 8-bit sum plus carry.
package adder_buf_pkg;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    IDLE = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 9;
  localparam int DEF_DEPTH  = 4;

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO holding adder results; DEPTH must be a power of two, at least 2.
// Pointers wrap naturally at their width, and the head reads as zero while empty.
module result_fifo #(
  parameter int DATA_W = 9,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A pop in the same cycle frees the slot, so a push at full is still accepted.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign rd_data = empty ? '0 : mem[rd_ptr];

  // NOTE: storage has no reset; only pointers and count need a known value, and
  // leaving the array unreset lets it map onto plain RAM/flop cells without reset muxes.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adder_result_buffer.sv
// Downstream stage of the pipelined adder: captures each sum on eno into a FIFO,
// presents it valid/ready, and only issues go when a FIFO slot is guaranteed.
module adder_result_buffer
  import adder_buf_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter bit DROP_FIRST = 1'b1,
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              eno,
  input  logic [DATA_W-1:0] sum_in,
  input  logic              go_req,
  output logic              go,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [CW-1:0]     count,
  output logic              busy,
  output logic              overflow
);

  localparam state_t RESET_STATE = DROP_FIRST ? SYNC : IDLE;

  state_t state;
  state_t state_next;
  logic   full;
  logic   empty;
  logic   pop;
  logic   eno_live;

  // The post-reset eno from the controller carries no data and is swallowed in SYNC.
  assign eno_live = eno && (state != SYNC);
  assign m_valid  = !empty;
  assign pop      = m_valid && m_ready;

  result_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (eno_live),
    .push_data (sum_in),
    .pop       (pop),
    .rd_data   (m_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RESET_STATE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    go         = 1'b0;
    busy       = 1'b0;
    case (state)
      SYNC: begin
        if (eno) state_next = IDLE;
      end
      IDLE: begin
        // Credit check: an issued request always has a slot when its result returns.
        go = go_req && !full;
        if (go) state_next = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (eno) state_next = IDLE;
      end
      default: state_next = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (eno_live && full && !pop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adder_result_buffer.sv
// Self-checking bench for adder_result_buffer: emulates the upstream controller
// (eno four cycles after go) and checks every cycle against a queue-based model.
module tb_adder_result_buffer;

  localparam int DATA_W = 9;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int VW     = 4 + DATA_W + CW;

  logic              clk = 1'b0;
  logic              reset;
  logic              eno;
  logic [DATA_W-1:0] sum_in;
  logic              go_req;
  logic              go;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [CW-1:0]     count;
  logic              busy;
  logic              overflow;

  adder_result_buffer #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .DROP_FIRST (1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .eno      (eno),
    .sum_in   (sum_in),
    .go_req   (go_req),
    .go       (go),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .count    (count),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Observed outputs packed as {go, m_valid, m_data, count, busy, overflow}.
  logic [VW-1:0] obs;
  assign obs = {go, m_valid, m_data, count, busy, overflow};

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int go_seen = 0;

  // Reference model: result queue, upstream in-flight flag, sync flag, sticky overflow.
  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] popped[$];
  logic [DATA_W-1:0] plan_sums[$];
  logic [DATA_W-1:0] due_sum[$];
  int                due_cyc[$];
  bit                synced, in_flight, ovf;

  logic              exp_go, exp_valid;
  logic [DATA_W-1:0] exp_data;
  logic [CW-1:0]     exp_count;
  logic [VW-1:0]     exp_vec;

  task automatic model_clear();
    q.delete();
    due_sum.delete();
    due_cyc.delete();
    plan_sums.delete();
    synced    = 1'b0;
    in_flight = 1'b0;
    ovf       = 1'b0;
  endtask

  function automatic bit eno_due();
    return (due_cyc.size() != 0) && (due_cyc[0] == cyc);
  endfunction

  // Drive one cycle's inputs just after the falling edge and compute expected outputs.
  task automatic drive(input logic gr, input logic mr, input logic uns,
                       input logic [DATA_W-1:0] uns_sum);
    go_req  = gr;
    m_ready = mr;
    eno     = uns;
    sum_in  = uns ? uns_sum : DATA_W'($urandom_range(0, 511));
    if (eno_due()) begin
      eno    = 1'b1;
      sum_in = due_sum.pop_front();
      void'(due_cyc.pop_front());
    end
    #1;
    exp_go    = gr && synced && !in_flight && (q.size() < DEPTH);
    exp_count = CW'(q.size());
    exp_valid = (q.size() != 0);
    exp_data  = exp_valid ? q[0] : '0;
    exp_vec   = {exp_go, exp_valid, exp_data, exp_count, in_flight, ovf};
  endtask

  // Apply the rising edge to the model, then move to the next falling edge.
  task automatic adv();
    if (exp_valid && m_ready) popped.push_back(q.pop_front());
    if (eno) begin
      if (!synced)                synced = 1'b1;
      else if (q.size() < DEPTH)  q.push_back(sum_in);
      else                        ovf = 1'b1;
    end
    if (in_flight && eno) begin
      in_flight = 1'b0;
    end else if (exp_go) begin
      in_flight = 1'b1;
      go_seen++;
      due_cyc.push_back(cyc + 4);
      due_sum.push_back(plan_sums.size() != 0 ? plan_sums.pop_front()
                                              : DATA_W'($urandom_range(0, 511)));
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_clear();
    drive(1'b1, 1'b1, 1'b0, '0);
    n_cmp++;
    if (obs !== exp_vec) begin
      n_bad++;
      $display("FAIL reset_state actual=%h required=%h", obs, exp_vec);
    end
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 9'h1FF);
    adv();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, '0);
      n_cmp++;
      if (obs !== exp_vec) begin
        n_bad++;
        $display("FAIL sync_drop cyc=%0d actual=%h required=%h", cyc, obs, exp_vec);
      end
      adv();
    end
  endtask

  task automatic test_back_to_back();
    int start = go_seen;
    popped.delete();
    plan_sums = '{9'h003, 9'h00A, 9'h100};
    for (int i = 0; i < 22; i++) begin
      drive(go_seen < start + 3, 1'b1, 1'b0, '0);
      n_cmp++;
      if (obs !== exp_vec) begin
        n_bad++;
        $display("FAIL back_to_back cyc=%0d actual=%h required=%h", cyc, obs, exp_vec);
      end
      adv();
    end
    n_cmp++;
    if (popped.size() != 3 || popped[0] !== 9'h003 || popped[1] !== 9'h00A ||
        popped[2] !== 9'h100) begin
      n_bad++;
      $display("FAIL b2b_order actual_n=%0d required_n=3", popped.size());
    end
  endtask

  task automatic test_fill_and_release();
    int start = go_seen;
    for (int i = 0; i < 30; i++) begin
      drive(1'b1, 1'b0, 1'b0, '0);
      n_cmp++;
      if (obs !== exp_vec) begin
        n_bad++;
        $display("FAIL fill cyc=%0d actual=%h required=%h", cyc, obs, exp_vec);
      end
      adv();
    end
    n_cmp++;
    if (go_seen - start != 4 || count !== CW'(4)) begin
      n_bad++;
      $display("FAIL fill_credit actual gos=%0d count=%0d required gos=4 count=4",
               go_seen - start, count);
    end
    for (int i = 0; i < 8; i++) begin
      drive(i < 7, i == 0, 1'b0, '0);
      n_cmp++;
      if (obs !== exp_vec) begin
        n_bad++;
        $display("FAIL release cyc=%0d actual=%h required=%h", cyc, obs, exp_vec);
      end
      adv();
    end
    n_cmp++;
    if (go_seen - start != 5 || count !== CW'(4)) begin
      n_bad++;
      $display("FAIL release_credit actual gos=%0d count=%0d required gos=5 count=4",
               go_seen - start, count);
    end
  endtask

  task automatic test_full_push_pop();
    drive(1'b0, 1'b1, 1'b1, 9'h055);
    n_cmp++;
    if (obs !== exp_vec) begin
      n_bad++;
      $display("FAIL full_pushpop cyc=%0d actual=%h required=%h", cyc, obs, exp_vec);
    end
    adv();
    drive(1'b0, 1'b0, 1'b0, '0);
    n_cmp++;
    if (overflow !== 1'b0 || count !== CW'(4) || obs !== exp_vec) begin
      n_bad++;
      $display("FAIL full_pushpop_after actual=%h required=%h", obs, exp_vec);
    end
    adv();
  endtask

  task automatic test_overflow();
    logic [DATA_W-1:0] head;
    head = q[0];
    drive(1'b0, 1'b0, 1'b1, 9'h066);
    adv();
    drive(1'b0, 1'b0, 1'b0, '0);
    n_cmp++;
    if (overflow !== 1'b1 || count !== CW'(4) || m_data !== head || obs !== exp_vec) begin
      n_bad++;
      $display("FAIL overflow actual=%h required=%h head_req=%h", obs, exp_vec, head);
    end
    adv();
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 3; i++) begin
      drive(i == 2, i < 2, 1'b0, '0);
      n_cmp++;
      if (obs !== exp_vec) begin
        n_bad++;
        $display("FAIL midop_setup cyc=%0d actual=%h required=%h", cyc, obs, exp_vec);
      end
      adv();
    end
    drive(1'b0, 1'b0, 1'b0, '0);
    n_cmp++;
    if (count !== CW'(2) || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL midop_pre actual count=%0d busy=%b required count=2 busy=1", count, busy);
    end
    #1;
    reset = 1'b0;
    model_clear();
    #1;
    n_cmp++;
    if (obs !== '0) begin
      n_bad++;
      $display("FAIL midop_async actual=%h required=%h", obs, {VW{1'b0}});
    end
    @(negedge clk);
    cyc++;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b1, DATA_W'($urandom_range(0, 511)));
    adv();
  endtask

  task automatic test_wrap();
    int start = go_seen;
    popped.delete();
    for (int v = 1; v <= 10; v++) plan_sums.push_back(DATA_W'(v));
    for (int i = 0; i < 60; i++) begin
      drive(go_seen < start + 10, 1'b1, 1'b0, '0);
      n_cmp++;
      if (obs !== exp_vec) begin
        n_bad++;
        $display("FAIL wrap cyc=%0d actual=%h required=%h", cyc, obs, exp_vec);
      end
      adv();
    end
    for (int v = 1; v <= 10; v++) begin
      n_cmp++;
      if (popped.size() < v || popped[v-1] !== DATA_W'(v)) begin
        n_bad++;
        $display("FAIL wrap_order idx=%0d actual=%h required=%h", v,
                 popped.size() >= v ? popped[v-1] : '0, DATA_W'(v));
      end
    end
    n_cmp++;
    if (count !== '0) begin
      n_bad++;
      $display("FAIL wrap_empty actual=%0d required=0", count);
    end
  endtask

  task automatic test_random();
    logic uns;
    for (int i = 0; i < 400; i++) begin
      uns = !eno_due() && ($urandom_range(0, 99) < 3);
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 1), uns,
            DATA_W'($urandom_range(0, 511)));
      n_cmp++;
      if (obs !== exp_vec) begin
        n_bad++;
        $display("FAIL random cyc=%0d actual=%h required=%h", cyc, obs, exp_vec);
      end
      adv();
    end
  endtask

  initial begin
    reset   = 1'b0;
    eno     = 1'b0;
    sum_in  = '0;
    go_req  = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_fill_and_release();
    test_full_push_pop();
    test_overflow();
    test_reset_midop();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adder_result_buffer.md
Name: adder_result_buffer

Overview:
Downstream stage of the pipelined-adder controller/datapath pair. Captures each sum when the controller pulses ENO and buffers results in a small FIFO. Presents results on a valid/ready output interface. Issues GO to the controller only when a FIFO slot is guaranteed, so no result is ever dropped in normal operation.

Parameters:
DATA_W, 9, width of captured sum (8-bit sum plus carry)
DEPTH, 4, FIFO entries; power of two, minimum 2
DROP_FIRST, 1, discard the first eno pulse after reset (upstream emits one data-less ENO on leaving reset)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
eno  in  1  result-valid pulse from controller, one cycle wide
sum_in  in  DATA_W  datapath result, valid in the eno cycle
go_req  in  1  user requests a new addition; level, may be held
go  out  1  to controller GO input
m_valid  out  1  output result available
m_ready  in  1  consumer accepts result
m_data  out  DATA_W  FIFO head
count  out  $clog2(DEPTH)+1  entries held
busy  out  1  an addition is in flight
overflow  out  1  sticky: eno arrived while FIFO full

Behaviour:
- Reset (reset=0, async): FSM to SYNC if DROP_FIRST=1, else IDLE. FIFO pointers and count 0; m_valid=0, m_data=0, overflow=0, busy=0, go=0.
- FSM states:
  - SYNC: wait for first eno and discard it (no push) -> IDLE.
  - IDLE: go = go_req && (count < DEPTH), combinational. If go=1 -> WAIT at the next edge.
  - WAIT: go=0, busy=1. On eno -> push sum_in -> IDLE.
- go is asserted for exactly one cycle per accepted request. The controller samples GO in its idle state; eno follows 4 cycles after the go cycle (go at cycle N, eno at N+4).
- Credit rule: go is never asserted when count==DEPTH. An in-flight result therefore always has a free slot, since pops only free space.
- Push: eno in IDLE or WAIT with count<DEPTH writes sum_in at the write pointer. eno in IDLE (unsolicited) is still pushed.
- Overflow: eno with count==DEPTH and no simultaneous pop -> data discarded, overflow set. overflow is cleared only by reset.
- Pop: m_valid && m_ready. m_valid = (count!=0). m_data = mem[rd_ptr], stable while m_valid && !m_ready.
- Latency: eno at edge N -> m_valid=1 and m_data valid after edge N (visible cycle N+1) when the FIFO was empty.
- Simultaneous push and pop: both performed, count unchanged. This is allowed at count==DEPTH (pop frees the slot in the same cycle, no overflow).
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Reset mid-operation (in WAIT): FSM returns to SYNC/IDLE and the FIFO empties. The upstream controller is reset by the same signal, so its post-reset ENO is absorbed by SYNC.
- go_req deasserted before go issues: no effect, nothing is latched.

Decomposition:
- Package adder_buf_pkg: state_t enum {SYNC, IDLE, WAIT}; default DATA_W/DEPTH localparams.
- Sub-module result_fifo: parameterised synchronous FIFO with push/pop/count/full/empty.
- Top level holds the FSM, go/credit logic and the overflow flag.

Test Plan:
- Reset release with DROP_FIRST=1, eno pulse on the first cycle with sum_in=9'h1FF -> no push, count=0, FSM reaches IDLE, m_valid=0.
- go_req=1 held, m_ready=1, eno with sums 0x03, 0x0A, 0x100 -> one go per op spaced by eno return; m_data sequence 0x03, 0x0A, 0x100, each m_valid for 1 cycle.
- m_ready=0, go_req=1 -> exactly 4 go pulses, count=4, go stays 0. Then m_ready=1 for 1 cycle -> count=3, next go issues.
- count=4, unsolicited eno with sum 0x55 and m_ready=0 -> overflow=1, count=4, head unchanged. Same with m_ready=1 -> pop and push, overflow stays 0.
- Reset asserted in WAIT with count=2 -> count=0, m_valid=0, busy=0 immediately (async), overflow cleared.
- Wrap-around: 10 push/pop pairs at DEPTH=4 with values 1..10 -> output order 1..10 intact, count returns to 0.
